// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_pkg
//  Description : Shared types and constants for the SDRAM word-port arbiter
//                (owner encoding, arbiter state encoding, memory map marks).
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

    // Which requester currently holds the SDRAM word port.
    typedef enum logic {
        OWN_C = 1'b0,   // CPU bus path
        OWN_H = 1'b1    // host copy/loader path
    } owner_t;

    // Arbiter state encoding, fixed width so the encoding is stable in netlists.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,  // choose the next owner
        ST_BUSY = 2'd1,  // command on the port, waiting for ram_ready edge
        ST_DONE = 2'd2   // ack held until the owner releases its request
    } arb_state_t;

    // Memory map marks reserved for a future write-protect check.
    localparam logic [24:0] ROM_START = 25'h100_0000;
    localparam logic [24:0] NOMEM     = 25'h1FF_FFFF;

    // Grant decision made in IDLE. The host wins when the CPU is quiet or when
    // the CPU has used up its burst allowance while the host was waiting.
    function automatic owner_t pick_owner(input logic c_req,
                                          input logic h_req,
                                          input logic burst_full);
        owner_t own;
        own = OWN_C;
        if (h_req && (!c_req || burst_full)) begin
            own = OWN_H;
        end
        return own;
    endfunction

endpackage : mem_pkg
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Two-port arbiter for the single SDRAM word port. Serialises
//                CPU (port C) and host loader (port H) accesses, detects
//                completion on the rising edge of ram_ready, returns level
//                acks, and bounds CPU bursts so the host always progresses.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int CPU_BURST = 4,
    parameter int TIMEOUT   = 255,
    parameter int AW        = 24
) (
    input  logic          clk_sys,
    input  logic          reset,

    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [15:0]   c_din,
    input  logic [1:0]    c_wtbt,
    output logic          c_ack,
    output logic [15:0]   c_dout,

    input  logic          h_req,
    input  logic          h_we,
    input  logic [AW-1:0] h_addr,
    input  logic [15:0]   h_din,
    output logic          h_ack,
    output logic [15:0]   h_dout,

    output logic [AW-1:0] ram_addr,
    output logic [15:0]   ram_din,
    output logic [1:0]    ram_wtbt,
    output logic          ram_we,
    output logic          ram_rd,
    input  logic [15:0]   ram_dout,
    input  logic          ram_ready,

    output logic          timeout_err
);

    // Counter widths sized to hold their terminal values.
    localparam int BW = $clog2(CPU_BURST + 1);
    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    localparam logic [BW-1:0] c_BURST_MAX = BW'(CPU_BURST);
    // Last BUSY cycle before abort: the command stays up for TIMEOUT cycles.
    localparam logic [TW-1:0] c_TMO_LAST  = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    arb_state_t    r_state;
    owner_t        r_owner;
    logic [BW-1:0] r_burst_cnt;
    logic [TW-1:0] r_tmo_cnt;
    logic          r_old_ready;

    logic          w_complete;
    logic          w_tmo_hit;
    logic          w_owner_req;
    logic          w_burst_full;
    owner_t        w_next_owner;

    // Completion, timeout and arbitration decode from the current registers.
    always_comb begin
        w_complete   = ~r_old_ready & ram_ready;
        w_tmo_hit    = (r_tmo_cnt == c_TMO_LAST);
        w_owner_req  = (r_owner == OWN_H) ? h_req : c_req;
        w_burst_full = (r_burst_cnt == c_BURST_MAX);
        w_next_owner = pick_owner(c_req, h_req, w_burst_full);
    end

    // Previous ram_ready sample; sampled every cycle so a ready that is
    // already high when BUSY is entered never looks like a new edge.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_old_ready <= 1'b0;
        end else begin
            r_old_ready <= ram_ready;
        end
    end

    // Arbiter FSM: grant in IDLE, run the command in BUSY, hold ack in DONE.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_owner     <= OWN_C;
            r_burst_cnt <= '0;
            r_tmo_cnt   <= '0;
            ram_addr    <= '0;
            ram_din     <= '0;
            ram_wtbt    <= '0;
            ram_we      <= 1'b0;
            ram_rd      <= 1'b0;
            c_ack       <= 1'b0;
            h_ack       <= 1'b0;
            c_dout      <= '0;
            h_dout      <= '0;
            timeout_err <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (h_req && (w_next_owner == OWN_H)) begin
                        // Host grant clears the CPU burst allowance.
                        r_owner     <= OWN_H;
                        r_burst_cnt <= '0;
                        ram_addr    <= h_addr;
                        ram_din     <= h_din;
                        ram_wtbt    <= 2'b11;
                        ram_we      <= h_we;
                        ram_rd      <= ~h_we;
                        r_tmo_cnt   <= '0;
                        r_state     <= ST_BUSY;
                    end else if (c_req) begin
                        // CPU grants only count against the burst while the
                        // host is actually waiting.
                        r_owner <= OWN_C;
                        if (h_req) begin
                            if (!w_burst_full) begin
                                r_burst_cnt <= r_burst_cnt + 1'b1;
                            end
                        end else begin
                            r_burst_cnt <= '0;
                        end
                        ram_addr  <= c_addr;
                        ram_din   <= c_din;
                        ram_wtbt  <= c_wtbt;
                        ram_we    <= c_we;
                        ram_rd    <= ~c_we;
                        r_tmo_cnt <= '0;
                        r_state   <= ST_BUSY;
                    end
                end

                ST_BUSY: begin
                    if (w_complete) begin
                        ram_we <= 1'b0;
                        ram_rd <= 1'b0;
                        if (r_owner == OWN_H) begin
                            h_ack <= 1'b1;
                            if (ram_rd) begin
                                h_dout <= ram_dout;
                            end
                        end else begin
                            c_ack <= 1'b1;
                            if (ram_rd) begin
                                c_dout <= ram_dout;
                            end
                        end
                        r_state <= ST_DONE;
                    end else if (w_tmo_hit) begin
                        // Abort: release the port, flag it, and still ack so
                        // the owner is never left hanging. Read data is stale.
                        ram_we      <= 1'b0;
                        ram_rd      <= 1'b0;
                        timeout_err <= 1'b1;
                        if (r_owner == OWN_H) begin
                            h_ack <= 1'b1;
                        end else begin
                            c_ack <= 1'b1;
                        end
                        r_state <= ST_DONE;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
                end

                ST_DONE: begin
                    // A request dropped during BUSY makes this a 1-cycle pulse.
                    if (!w_owner_req) begin
                        c_ack   <= 1'b0;
                        h_ack   <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end

                default: begin
                    ram_we  <= 1'b0;
                    ram_rd  <= 1'b0;
                    c_ack   <= 1'b0;
                    h_ack   <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : mem_arbiter
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Self-checking bench for mem_arbiter: table-driven single
//                transactions plus directed burst, timeout, dropped-request
//                and mid-access reset sequences against a simple SDRAM model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;
    import mem_pkg::*;

    localparam int AW = 24;

    logic          clk_sys = 1'b0;
    logic          reset   = 1'b1;
    logic          c_req = 1'b0, c_we = 1'b0;
    logic [AW-1:0] c_addr = '0;
    logic [15:0]   c_din = '0;
    logic [1:0]    c_wtbt = '0;
    logic          c_ack;
    logic [15:0]   c_dout;
    logic          h_req = 1'b0, h_we = 1'b0;
    logic [AW-1:0] h_addr = '0;
    logic [15:0]   h_din = '0;
    logic          h_ack;
    logic [15:0]   h_dout;
    logic [AW-1:0] ram_addr;
    logic [15:0]   ram_din;
    logic [1:0]    ram_wtbt;
    logic          ram_we, ram_rd;
    logic [15:0]   ram_dout = '0;
    logic          ram_ready;
    logic          timeout_err;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   lat     = 2;      // model: cycles of command before ready rises
    logic stuck   = 1'b0;   // model: hold ready high regardless of command

    mem_arbiter dut (
        .clk_sys(clk_sys), .reset(reset),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_din(c_din), .c_wtbt(c_wtbt),
        .c_ack(c_ack), .c_dout(c_dout),
        .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_din(h_din),
        .h_ack(h_ack), .h_dout(h_dout),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_wtbt(ram_wtbt),
        .ram_we(ram_we), .ram_rd(ram_rd), .ram_dout(ram_dout), .ram_ready(ram_ready),
        .timeout_err(timeout_err)
    );

    initial forever #5 clk_sys = ~clk_sys;

    // SDRAM model: ready rises after 'lat' observed command cycles, falls when
    // the command drops.
    initial begin
        int mcnt;
        mcnt      = 0;
        ram_ready = 1'b0;
        forever begin
            @(negedge clk_sys);
            if (stuck) begin
                ram_ready = 1'b1;
                mcnt      = 0;
            end else if (ram_rd || ram_we) begin
                mcnt++;
                if (mcnt >= lat) ram_ready = 1'b1;
            end else begin
                mcnt      = 0;
                ram_ready = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic          host;
        logic          we;
        logic [AW-1:0] addr;
        logic [15:0]   din;
        logic [1:0]    wtbt;
        int            lat;
        logic [15:0]   rdata;
        logic [1:0]    exp_wtbt;
        logic [15:0]   exp_dout;
        int            exp_acklat;
    } vec_t;

    vec_t vecs[5];

    task automatic run_vec(input int idx, input vec_t v);
        int            cmdcyc, acklat;
        logic          got, other, cap, we_s, rd_s;
        logic [AW-1:0] a;
        logic [15:0]   d;
        logic [1:0]    w;
        cmdcyc = 0; acklat = 0; got = 0; other = 0; cap = 0;
        we_s = 0; rd_s = 0; a = '0; d = '0; w = '0;
        lat      = v.lat;
        ram_dout = v.rdata;
        if (v.host) begin
            h_we = v.we; h_addr = v.addr; h_din = v.din; h_req = 1'b1;
        end else begin
            c_we = v.we; c_addr = v.addr; c_din = v.din; c_wtbt = v.wtbt; c_req = 1'b1;
        end
        for (int k = 1; k <= 200 && !got; k++) begin
            @(negedge clk_sys);
            if (ram_rd || ram_we) begin
                cmdcyc++;
                if (!cap) begin
                    cap = 1; a = ram_addr; d = ram_din; w = ram_wtbt; we_s = ram_we; rd_s = ram_rd;
                end
            end
            if (v.host ? c_ack : h_ack) other = 1;
            if (v.host ? h_ack : c_ack) begin got = 1; acklat = k; end
        end
        check($sformatf("v%0d ack_seen", idx), 32'(got), 32'd1);
        check($sformatf("v%0d ack_latency", idx), acklat, v.exp_acklat);
        check($sformatf("v%0d cmd_cycles", idx), cmdcyc, v.lat);
        check($sformatf("v%0d ram_addr", idx), 32'(a), 32'(v.addr));
        check($sformatf("v%0d ram_din", idx), 32'(d), 32'(v.din));
        check($sformatf("v%0d ram_wtbt", idx), 32'(w), 32'(v.exp_wtbt));
        check($sformatf("v%0d ram_we/rd", idx), {30'd0, we_s, rd_s}, {30'd0, v.we, ~v.we});
        check($sformatf("v%0d other_ack", idx), 32'(other), 32'd0);
        check($sformatf("v%0d dout", idx), 32'(v.host ? h_dout : c_dout), 32'(v.exp_dout));
        if (v.host) h_req = 1'b0; else c_req = 1'b0;
        @(negedge clk_sys);
        check($sformatf("v%0d ack_drop", idx), 32'(v.host ? h_ack : c_ack), 32'd0);
    endtask

    initial begin
        int   own_seen[6];
        int   exp_own[6];
        int   ng, burst_at_h, burst_at_c4, cmdcyc, cack_n, st_after, spur;
        logic prev, cur, c_to, h_to, got, hcmd, st_rec;
        logic [15:0] hd;
        logic [1:0]  hw;

        //               host  we    addr         din       wtbt   lat rdata     ewtbt  edout     acklat
        vecs[0] = '{1'b0, 1'b0, 24'h00A000, 16'h0000, 2'b00, 5, 16'h1234, 2'b00, 16'h1234, 6};
        vecs[1] = '{1'b1, 1'b1, 24'h000100, 16'hBEEF, 2'b00, 3, 16'h5555, 2'b11, 16'h0000, 4};
        vecs[2] = '{1'b0, 1'b1, 24'h00A002, 16'h7777, 2'b10, 2, 16'h9999, 2'b10, 16'h1234, 3};
        vecs[3] = '{1'b1, 1'b0, 24'h000200, 16'h0000, 2'b00, 4, 16'hCAFE, 2'b11, 16'hCAFE, 5};
        vecs[4] = '{1'b0, 1'b0, 24'h00A004, 16'h0000, 2'b01, 1, 16'h0F0F, 2'b01, 16'h0F0F, 2};
        exp_own = '{0, 0, 0, 0, 1, 0};

        // ---- reset state ----
        repeat (2) @(negedge clk_sys);
        check("rst c_ack/h_ack", {30'd0, c_ack, h_ack}, 32'd0);
        check("rst ram_we/rd", {30'd0, ram_we, ram_rd}, 32'd0);
        check("rst ram_addr", 32'(ram_addr), 32'd0);
        check("rst douts", {c_dout, h_dout}, 32'd0);
        check("rst timeout_err", 32'(timeout_err), 32'd0);
        reset = 1'b0;
        @(negedge clk_sys);

        // ---- table-driven single transactions ----
        for (int i = 0; i < 5; i++) begin
            run_vec(i, vecs[i]);
            @(negedge clk_sys);
        end

        // ---- burst fairness: both requesting from reset exit ----
        reset = 1'b1;
        @(negedge clk_sys);
        reset = 1'b0;
        lat = 2; ram_dout = 16'h2468;
        ng = 0; prev = 0; burst_at_h = -1; burst_at_c4 = -1; c_to = 0; h_to = 0;
        fork
            begin
                logic cg;
                for (int t = 0; t < 5; t++) begin
                    c_we = 1'b0; c_addr = 24'h00C000; c_req = 1'b1; cg = 0;
                    for (int k = 0; k < 100 && !cg; k++) begin
                        @(negedge clk_sys);
                        if (c_ack) cg = 1;
                    end
                    if (!cg) c_to = 1;
                    c_req = 1'b0;
                    @(negedge clk_sys);
                end
            end
            begin
                logic hg;
                h_we = 1'b0; h_addr = 24'h00D000; h_req = 1'b1; hg = 0;
                for (int k = 0; k < 200 && !hg; k++) begin
                    @(negedge clk_sys);
                    if (h_ack) hg = 1;
                end
                if (!hg) h_to = 1;
                h_req = 1'b0;
                @(negedge clk_sys);
            end
            begin
                for (int k = 0; k < 400 && ng < 6; k++) begin
                    @(negedge clk_sys);
                    cur = ram_rd | ram_we;
                    if (cur && !prev) begin
                        own_seen[ng] = (ram_addr == 24'h00D000) ? 1 : 0;
                        if (ram_addr == 24'h00D000) burst_at_h = int'(dut.r_burst_cnt);
                        if (ng == 3) burst_at_c4 = int'(dut.r_burst_cnt);
                        ng++;
                    end
                    prev = cur;
                end
            end
        join
        check("burst timeouts", {30'd0, c_to, h_to}, 32'd0);
        check("burst grant_count", ng, 6);
        for (int i = 0; i < 6; i++)
            if (i < ng) check($sformatf("burst grant%0d owner", i), own_seen[i], exp_own[i]);
        check("burst cnt at 4th C", burst_at_c4, 4);
        check("burst cnt after H", burst_at_h, 0);

        // ---- timeout with ram_ready stuck high ----
        stuck = 1'b1;
        repeat (2) @(negedge clk_sys);
        ram_dout = 16'hDEAD;
        c_we = 1'b0; c_addr = 24'h00E000; c_req = 1'b1;
        cmdcyc = 0; got = 0;
        for (int k = 0; k < 400 && !got; k++) begin
            @(negedge clk_sys);
            if (ram_rd || ram_we) cmdcyc++;
            if (c_ack) got = 1;
        end
        check("tmo ack", 32'(got), 32'd1);
        check("tmo cmd_cycles", cmdcyc, 255);
        check("tmo timeout_err", 32'(timeout_err), 32'd1);
        check("tmo c_dout kept", 32'(c_dout), 32'h2468);
        c_req = 1'b0; stuck = 1'b0;
        @(negedge clk_sys);
        check("tmo ack_drop", 32'(c_ack), 32'd0);
        @(negedge clk_sys);

        // ---- CPU drops request mid-BUSY, host waiting ----
        lat = 6; ram_dout = 16'h1357;
        c_we = 1'b0; c_addr = 24'h00F000; c_req = 1'b1;
        got = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk_sys);
            if (ram_rd) got = 1;
        end
        check("drop cmd_seen", 32'(got), 32'd1);
        @(negedge clk_sys);
        c_req = 1'b0;
        h_we = 1'b1; h_addr = 24'h000300; h_din = 16'h0A0A; h_req = 1'b1;
        cack_n = 0; got = 0; hcmd = 0; st_rec = 0; st_after = -1; hd = '0; hw = '0;
        for (int k = 0; k < 60 && !got; k++) begin
            @(negedge clk_sys);
            if (c_ack) cack_n++;
            else if (cack_n == 1 && !st_rec) begin st_after = int'(dut.r_state); st_rec = 1; end
            if (ram_we && ram_addr == 24'h000300 && !hcmd) begin hcmd = 1; hd = ram_din; hw = ram_wtbt; end
            if (h_ack) got = 1;
        end
        check("drop c_ack pulse_len", cack_n, 1);
        check("drop c_dout", 32'(c_dout), 32'h1357);
        check("drop state_idle", st_after, int'(ST_IDLE));
        check("drop host_granted", {30'd0, hcmd, got}, 32'd3);
        check("drop host din/wtbt", {14'd0, hw, hd}, {14'd0, 2'b11, 16'h0A0A});
        h_req = 1'b0;
        repeat (2) @(negedge clk_sys);
        check("sticky timeout_err", 32'(timeout_err), 32'd1);

        // ---- async reset mid-BUSY ----
        lat = 50;
        c_we = 1'b0; c_addr = 24'h00A100; c_req = 1'b1;
        got = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk_sys);
            if (ram_rd) got = 1;
        end
        check("rstmid cmd_seen", 32'(got), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("rstmid cmd_acks", {28'd0, ram_we, ram_rd, c_ack, h_ack}, 32'd0);
        check("rstmid state", int'(dut.r_state), int'(ST_IDLE));
        check("rstmid timeout_err", 32'(timeout_err), 32'd0);
        c_req = 1'b0;
        @(negedge clk_sys);
        reset = 1'b0;
        lat = 2;
        spur = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk_sys);
            if (c_ack || h_ack || ram_rd || ram_we) spur++;
        end
        check("rstmid no_spurious", spur, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_mem_arbiter
`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single SDRAM word port (sram) between two requesters: the CPU bus path (port C) and the host copy/loader path (port H, which drives ROM/RAM image loads and dumps).
- Sits between the memory mapper and sram, replacing direct muxing on mem_copy.
- Serialises accesses, detects completion on the rising edge of ram_ready, returns level acks, and guarantees forward progress for the host port under continuous CPU traffic.

Parameters:
- CPU_BURST, 4: max consecutive CPU grants while H is pending before H must be granted.
- TIMEOUT, 255: cycles to wait for ram_ready before aborting an access.
- AW, 24: word address width.

Ports:
- clk_sys  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- c_req  in  1  CPU request, level; fields stable while high.
- c_we  in  1  CPU write (0 = read).
- c_addr  in  AW  CPU word address.
- c_din  in  16  CPU write data.
- c_wtbt  in  2  CPU byte enables (write only).
- c_ack  out  1  CPU completion, level.
- c_dout  out  16  CPU read data.
- h_req  in  1  host request, level.
- h_we  in  1  host write.
- h_addr  in  AW  host word address.
- h_din  in  16  host write data.
- h_ack  out  1  host completion, level.
- h_dout  out  16  host read data.
- ram_addr  out  AW  to sram.
- ram_din  out  16  to sram.
- ram_wtbt  out  2  to sram.
- ram_we  out  1  to sram.
- ram_rd  out  1  to sram.
- ram_dout  in  16  from sram.
- ram_ready  in  1  from sram; completion is its rising edge.
- timeout_err  out  1  sticky, set when an access times out.

Behaviour:
- Reset (async) values: all outputs 0; state IDLE; burst_cnt 0; tmo_cnt 0; old_ready 0.
- States:
  - IDLE: pick owner.
  - BUSY: command asserted, waiting for completion.
  - DONE: ack held, waiting for the owner to drop its request.
- IDLE arbitration (registered, evaluated each cycle):
  - If h_req and (not c_req or burst_cnt == CPU_BURST): owner = H, burst_cnt reset to 0.
  - Else if c_req: owner = C; burst_cnt increments only when h_req is also high, saturating at CPU_BURST. If h_req is low, burst_cnt resets to 0.
  - Else stay in IDLE.
  - On grant, next cycle: state BUSY; ram_addr/ram_din/ram_wtbt latched from the owner; ram_we = we; ram_rd = ~we; tmo_cnt = 0.
  - H always uses ram_wtbt = 2'b11.
- BUSY:
  - Command lines held stable.
  - old_ready <= ram_ready every cycle.
  - Completion = ~old_ready & ram_ready. A ready that is already high at entry does not count; a new rising edge is required.
  - On completion: ram_we = ram_rd = 0; owner's dout <= ram_dout on reads (on writes, dout is left unchanged); owner's ack = 1; go to DONE.
  - tmo_cnt increments each cycle. At TIMEOUT: drop the command, set timeout_err, assert ack (dout unchanged), go to DONE.
- DONE: ack held high while the owner's req is high. When the owner's req goes low, ack drops the same cycle (registered), and state returns to IDLE. At least one IDLE cycle separates grants.
- Latency: req high in cycle 0, command in cycle 1, ack in the cycle after the ready edge is sampled. Minimum 3 cycles from request to ack.
- Dropped request in BUSY: the access completes normally (the SDRAM op cannot be cancelled). On entering DONE with req already low, ack pulses for one cycle and state returns to IDLE.
- Non-owner requests stay pending, with no ack, until granted.
- Simultaneous c_req and h_req in IDLE with burst_cnt < CPU_BURST: C wins.
- dout registers persist until the next read by the same port.
- timeout_err is cleared only by reset.
- Reset mid-access: command lines drop immediately. No ack is generated.

Decomposition:
- Shared package mem_pkg:
  - typedef owner_t {OWN_C, OWN_H}.
  - typedef arb_state_t {ST_IDLE, ST_BUSY, ST_DONE}.
  - Constants ROM_START and NOMEM (25-bit) for future write-protect use.
- Single module; no sub-module needed. Edge detect and counters are inline.

Test Plan:
- CPU read: c_req=1, c_we=0, c_addr=24'h00A000; ready rises 5 cycles after ram_rd → ram_rd high for exactly 5 cycles, c_dout = ram_dout (16'h1234), c_ack high until c_req drops, then 0 next cycle.
- Host write: h_req=1, h_we=1, h_din=16'hBEEF → ram_we=1, ram_wtbt=2'b11, ram_din=16'hBEEF; h_ack after the ready edge; c_ack stays 0 throughout.
- Simultaneous requests at reset exit, CPU_BURST=4, c_req re-asserted every cycle after ack → grant order C,C,C,C,H,C; burst_cnt returns to 0 after the H grant.
- ram_ready stuck high at BUSY entry, no edge for 255 cycles → command drops at cycle 255, timeout_err=1, ack asserted, c_dout unchanged.
- c_req dropped 2 cycles into BUSY, ready edge 4 cycles later → access completes, c_ack is a 1-cycle pulse, state returns to IDLE, h_req granted afterward.
- Async reset asserted mid-BUSY → ram_we, ram_rd, c_ack and h_ack all 0 within the same cycle, state IDLE; no spurious ack after release.
